div_req_ctrl: RTL and testbench

- EX-stage requester for the multi-cycle DIV/DIVU divider; it drives the divider's start/annul/operand inputs and consumes its ready/result outputs.
- Captures operands when a divide enters EX, holds them stable while the divider runs, and requests a pipeline stall.
- On completion it presents the HI/LO write (HI = remainder, LO = quotient) until the instruction leaves EX.
- On a pipeline cancel it annuls the divider and drains it back to free before another divide may issue.

---
 rtl/div_req_ctrl_pkg.sv | 17 +
 rtl/div_req_ctrl.sv | 133 +++++++++++++
 tb/tb_div_req_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/div_req_ctrl_pkg.sv
// Shared encodings for the EX-stage divider requester.
package div_req_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } div_state_t;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_req_ctrl.sv
// EX-stage requester for the multi-cycle DIV/DIVU unit: issues, holds
// operands, stalls the pipe, presents HI/LO on completion, drains on cancel.
module div_req_ctrl
    import div_req_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_rs_i,
    input  logic [31:0] ex_rt_i,
    input  logic        ex_cancel_i,
    input  logic        ex_stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        signed_div_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    output logic        start_o,
    output logic        annul_o,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    div_state_t       state;
    logic [CNT_W-1:0] drain_cnt;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;
    logic             signed_q;
    logic [63:0]      result_q;
    logic             issue;

    assign issue = ex_div_valid_i & ~ex_cancel_i;

    // Controller state, drain counter and latched operands/result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            rs_q      <= ZeroWord;
            rt_q      <= ZeroWord;
            signed_q  <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        rs_q     <= ex_rs_i;
                        rt_q     <= ex_rt_i;
                        signed_q <= ex_signed_i;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // A cancel wins over a simultaneous ready: the result is dropped.
                    if (ex_cancel_i) begin
                        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                        state     <= DRAIN;
                    end else if (div_ready_i == DivResultReady) begin
                        result_q <= div_result_i;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // Hold here while EX is stalled so the same divide never re-issues.
                    if (ex_cancel_i || !ex_stall_i) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Divider and pipeline-facing outputs decoded from state
    always_comb begin
        signed_div_o = 1'b0;
        opdata1_o    = ZeroWord;
        opdata2_o    = ZeroWord;
        start_o      = DivStop;
        annul_o      = 1'b0;
        stall_req_o  = 1'b0;
        hilo_we_o    = 1'b0;
        hi_o         = ZeroWord;
        lo_o         = ZeroWord;
        case (state)
            IDLE: begin
                if (issue) begin
                    signed_div_o = ex_signed_i;
                    opdata1_o    = ex_rs_i;
                    opdata2_o    = ex_rt_i;
                    start_o      = DivStart;
                    stall_req_o  = 1'b1;
                end
            end
            BUSY: begin
                signed_div_o = signed_q;
                opdata1_o    = rs_q;
                opdata2_o    = rt_q;
                stall_req_o  = 1'b1;
                if (ex_cancel_i) begin
                    annul_o = 1'b1;
                end else begin
                    start_o = DivStart;
                end
            end
            DONE: begin
                hilo_we_o = ~ex_cancel_i;
                hi_o      = result_q[63:32];
                lo_o      = result_q[31:0];
            end
            DRAIN: begin
                annul_o     = 1'b1;
                stall_req_o = ex_div_valid_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl with a behavioural divider responder.
module tb_div_req_ctrl;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_signed_i;
    logic [31:0] ex_rs_i;
    logic [31:0] ex_rt_i;
    logic        ex_cancel_i;
    logic        ex_stall_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        signed_div_o;
    logic [31:0] opdata1_o;
    logic [31:0] opdata2_o;
    logic        start_o;
    logic        annul_o;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_req_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_div_valid_i (ex_div_valid_i),
        .ex_signed_i    (ex_signed_i),
        .ex_rs_i        (ex_rs_i),
        .ex_rt_i        (ex_rt_i),
        .ex_cancel_i    (ex_cancel_i),
        .ex_stall_i     (ex_stall_i),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .signed_div_o   (signed_div_o),
        .opdata1_o      (opdata1_o),
        .opdata2_o      (opdata2_o),
        .start_o        (start_o),
        .annul_o        (annul_o),
        .stall_req_o    (stall_req_o),
        .hilo_we_o      (hilo_we_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    // Divider reference: {remainder, quotient}, zero on divide by zero
    function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (s) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    // Responder: counts while started, then raises ready; stopping frees it
    int unsigned dcnt;
    always_ff @(posedge clk) begin
        if (rst || start_o != 1'b1 || annul_o) begin
            dcnt        <= 0;
            div_ready_i <= 1'b0;
        end else if (dcnt == LAT) begin
            div_ready_i  <= 1'b1;
            div_result_i <= div_ref(signed_div_o, opdata1_o, opdata2_o);
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] rs, input logic [31:0] rt, input logic sgn);
        @(negedge clk);
        ex_div_valid_i = 1'b1;
        ex_signed_i    = sgn;
        ex_rs_i        = rs;
        ex_rt_i        = rt;
        ex_cancel_i    = 1'b0;
        ex_stall_i     = 1'b0;
        #1;
        chk("issue_start", start_o, 1);
        chk("issue_stall", stall_req_o, 1);
        chk("issue_ops", {signed_div_o, opdata1_o, opdata2_o}, {sgn, rs, rt});
    endtask

    task automatic finish_div(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int hold);
        int cyc = 0;
        int nostall = 0;
        do begin
            @(negedge clk);
            if (cyc == 0) begin
                ex_rs_i     = 32'hDEAD_BEEF;
                ex_rt_i     = 32'h0000_1234;
                ex_signed_i = ~ex_signed_i;
            end
            #1;
            if (!hilo_we_o && !stall_req_o) nostall++;
            cyc++;
        end while (!hilo_we_o && cyc < 200);
        chk("done_reached", hilo_we_o, 1);
        chk("busy_stalled", nostall, 0);
        chk("done_hi", hi_o, exp_hi);
        chk("done_lo", lo_o, exp_lo);
        chk("done_start_low", start_o, 0);
        chk("done_no_stall", stall_req_o, 0);
        if (hold > 0) begin
            ex_stall_i = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                #1;
                chk("hold_out", {hilo_we_o, start_o, hi_o, lo_o}, {1'b1, 1'b0, exp_hi, exp_lo});
            end
            @(negedge clk);
            ex_stall_i = 1'b0;
        end
        ex_div_valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("after_done", {hilo_we_o, start_o, stall_req_o}, 3'b000);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        ex_signed_i    = 1'b0;
        ex_rs_i        = 32'd0;
        ex_rt_i        = 32'd0;
        ex_cancel_i    = 1'b0;
        ex_stall_i     = 1'b0;
        div_result_i   = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outs", |{signed_div_o, opdata1_o, opdata2_o, start_o, annul_o,
                             stall_req_o, hilo_we_o, hi_o, lo_o}, 0);

        issue(32'd7, 32'd2, 1'b1);
        finish_div(32'd1, 32'd3, 0);

        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        finish_div(32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        finish_div(32'd0, 32'hFFFF_FFFF, 0);

        issue(32'd5, 32'd0, 1'b0);
        finish_div(32'd0, 32'd0, 0);

        // Cancel mid-BUSY, then a new divide waits out the drain
        issue(32'd100, 32'd7, 1'b1);
        repeat (10) @(negedge clk);
        ex_cancel_i = 1'b1;
        #1;
        chk("cancel_outs", {annul_o, start_o, hilo_we_o}, 3'b100);
        @(negedge clk);
        ex_cancel_i    = 1'b0;
        ex_div_valid_i = 1'b1;
        ex_signed_i    = 1'b1;
        ex_rs_i        = 32'd9;
        ex_rt_i        = 32'd3;
        #1;
        n = 0;
        while (annul_o && n < 10) begin
            chk("drain_outs", {stall_req_o, hilo_we_o, start_o}, 3'b100);
            n++;
            @(negedge clk);
            #1;
        end
        chk("drain_len", n, 3);
        chk("post_drain_issue", {start_o, annul_o, opdata1_o, opdata2_o}, {1'b1, 1'b0, 32'd9, 32'd3});
        finish_div(32'd0, 32'd3, 0);

        // Stall held in DONE
        issue(32'd20, 32'd6, 1'b0);
        finish_div(32'd2, 32'd3, 4);

        // Reset mid-BUSY
        issue(32'd50, 32'd5, 1'b0);
        repeat (5) @(negedge clk);
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_outs", |{signed_div_o, opdata1_o, opdata2_o, start_o, annul_o,
                              stall_req_o, hilo_we_o, hi_o, lo_o}, 0);
        rst = 1'b0;
        issue(32'd8, 32'd2, 1'b1);
        finish_div(32'd0, 32'd4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
